// File: rtl/pb_debounce_pkg.sv
// -----------------------------------------------------------------------------
// pb_debounce_pkg
//
// Shared constants and types for the switch-pad debouncer.
//   PB_DB_STABLE_SIM    : short qualification time for simulation builds.
//   PB_DB_STABLE_50MHZ  : 1 ms qualification time at a 50 MHz system clock.
//   pb_db_state_e       : per-bit filter state (STABLE / PENDING).
// -----------------------------------------------------------------------------
package pb_debounce_pkg;

  localparam int unsigned PB_DB_STABLE_SIM   = 4;
  localparam int unsigned PB_DB_STABLE_50MHZ = 50000;

  typedef enum logic {
    PB_DB_STABLE  = 1'b0,  // synchronised level agrees with the debounced level
    PB_DB_PENDING = 1'b1   // a new level is being qualified
  } pb_db_state_e;

endpackage : pb_debounce_pkg

// File: rtl/pb_debounce_bit.sv
// -----------------------------------------------------------------------------
// pb_debounce_bit
//
// One-bit switch conditioner: two-flop synchroniser, stability counter with a
// two-state filter FSM, and (optionally) registered rise/fall pulse outputs.
//
// Configuration macro: PB_DEBOUNCE_EDGE_EN
//   defined   : rise_o / fall_o are registered single-cycle edge pulses.
//   undefined : rise_o / fall_o are tied to 0, no delay register is built.
//
// Ports
//   clk_i    in   system clock
//   rst_n_i  in   asynchronous reset, active low
//   pad_i    in   raw asynchronous pad level
//   db_o     out  debounced level
//   rise_o   out  one-cycle pulse, the cycle after db_o goes 0->1
//   fall_o   out  one-cycle pulse, the cycle after db_o goes 1->0
// -----------------------------------------------------------------------------
module pb_debounce_bit
  import pb_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = PB_DB_STABLE_50MHZ,
  parameter logic        RESET_BIT     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic pad_i,
  output logic db_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned     CNT_W = $clog2(STABLE_CYCLES + 1);
  // Terminal count: the level has now been seen for STABLE_CYCLES cycles.
  localparam logic [CNT_W-1:0] TERM = CNT_W'(STABLE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  pb_db_state_e     state_q, state_d;

  logic differ;
  logic terminal;

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments make s1 and s2 sample together on the same
  // edge; blocking ones would collapse the two stages into one.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_q <= RESET_BIT;
      s2_q <= RESET_BIT;
    end else begin
      s1_q <= pad_i;
      s2_q <= s1_q;
    end
  end

  assign differ   = (s2_q != db_q);
  assign terminal = (cnt_q == TERM);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= PB_DB_STABLE;
      cnt_q   <= '0;
      db_q    <= RESET_BIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  // With STABLE_CYCLES == 1 the terminal count is 0, so a differing level is
  // accepted straight from STABLE without ever visiting PENDING.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PB_DB_STABLE: begin
        if (differ && !terminal) state_d = PB_DB_PENDING;
      end
      PB_DB_PENDING: begin
        if (!differ || terminal) state_d = PB_DB_STABLE;
      end
      default: state_d = PB_DB_STABLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (counter and debounced level)
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (differ) begin
      if (terminal) begin
        db_d = s2_q;               // qualified: accept the new level
      end else begin
        cnt_d = cnt_q + 1'b1;      // never wraps: terminal compare comes first
      end
    end
    // Level back at db before terminal count: counter clears, no partial credit.
  end

  assign db_o = db_q;

  // ---------------------------------------------------------------------------
  // Edge pulses
  // ---------------------------------------------------------------------------
`ifdef PB_DEBOUNCE_EDGE_EN
  logic db_dly_q;
  logic rise_q, fall_q;

  // db_dly_q resets to the same value as db_q, so reset release never looks
  // like an edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      db_dly_q <= RESET_BIT;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      db_dly_q <= db_q;
      rise_q   <= db_q & ~db_dly_q;
      fall_q   <= ~db_q & db_dly_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule : pb_debounce_bit

// File: rtl/pb_debounce.sv
// -----------------------------------------------------------------------------
// pb_debounce
//
// WIDTH independent switch-pad debouncers between the board pads and the
// switches GPIO block. Each bit is synchronised, then a new level is accepted
// only after holding for STABLE_CYCLES consecutive synchronised cycles.
//
// Configuration macro: PB_DEBOUNCE_EDGE_EN
//   defined   : rise_o / fall_o / change_o carry registered edge pulses.
//   undefined : rise_o / fall_o / change_o are constant 0; db_o unchanged.
//
// Parameters
//   WIDTH          number of input bits
//   STABLE_CYCLES  qualification time in clk_i cycles (>= 1)
//   RESET_VALUE    reset value of the synchronisers and db_o
//
// Ports
//   clk_i     in   system clock
//   rst_n_i   in   asynchronous reset, active low
//   pad_i     in   raw asynchronous switch levels
//   db_o      out  debounced levels
//   rise_o    out  per-bit one-cycle pulse after a 0->1 on db_o
//   fall_o    out  per-bit one-cycle pulse after a 1->0 on db_o
//   change_o  out  OR of all rise_o and fall_o bits (interrupt source)
// -----------------------------------------------------------------------------
module pb_debounce
  import pb_debounce_pkg::*;
#(
  parameter int unsigned      WIDTH         = 8,
  parameter int unsigned      STABLE_CYCLES = PB_DB_STABLE_50MHZ,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] db_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             change_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pb_debounce_bit #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .RESET_BIT     (RESET_VALUE[i])
    ) u_bit (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .pad_i   (pad_i[i]),
      .db_o    (db_o[i]),
      .rise_o  (rise_o[i]),
      .fall_o  (fall_o[i])
    );
  end

  // Pulses are already registered per bit, so this OR stays single-cycle.
  assign change_o = |(rise_o | fall_o);

endmodule : pb_debounce
